// File: rtl/mas_mul_issue_ctrl.sv
// Issue and result-collection controller for the fixed-latency 32x32 Booth multiplier core.
// Define MAS_MUL_ACC_EN to add the s_acc input and the 64-bit running accumulator.
module mas_mul_issue_ctrl #(
  parameter int LAT       = 1,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_in1,
  input  logic [31:0]      s_in2,
  input  logic [TAG_W-1:0] s_tag,
`ifdef MAS_MUL_ACC_EN
  input  logic             s_acc,
`endif
  output logic [31:0]      mul_in1,
  output logic [31:0]      mul_in2,
  input  logic [63:0]      mul_res,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_res,
  output logic [TAG_W-1:0] m_tag,
  output logic             busy
);

  localparam int PW = $clog2(RES_DEPTH);
  localparam logic [PW:0] ONE     = (PW+1)'(1);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RES_DEPTH);

  logic             issue;
  logic             pop;
  logic             wr_en;
  logic             full;
  logic [LAT:0]     vpipe;
  logic [TAG_W-1:0] tpipe [LAT+1];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [PW:0]      outstanding;
  logic [PW:0]      out_next;
  logic [63:0]      res_mem [RES_DEPTH];
  logic [TAG_W-1:0] tag_mem [RES_DEPTH];
  logic [63:0]      entry;

  assign issue   = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign wr_en   = vpipe[LAT];
  assign m_valid = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign m_res   = res_mem[rd_ptr[PW-1:0]];
  assign m_tag   = tag_mem[rd_ptr[PW-1:0]];
  assign busy    = (outstanding != '0);

  // The last pipe stage lines up with the cycle in which mul_res carries that issue's product.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_in1 <= '0;
      mul_in2 <= '0;
      vpipe   <= '0;
      for (int i = 0; i <= LAT; i++) tpipe[i] <= '0;
    end else begin
      if (issue) begin
        mul_in1 <= s_in1;
        mul_in2 <= s_in2;
      end
      vpipe    <= {vpipe[LAT-1:0], issue};
      tpipe[0] <= s_tag;
      for (int i = 1; i <= LAT; i++) tpipe[i] <= tpipe[i-1];
    end
  end

`ifdef MAS_MUL_ACC_EN
  logic [LAT:0] apipe;
  logic [63:0]  acc_r;

  assign entry = apipe[LAT] ? (acc_r + mul_res) : mul_res;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      apipe <= '0;
      acc_r <= '0;
    end else begin
      apipe <= {apipe[LAT-1:0], s_acc};
      if (wr_en) acc_r <= entry;
    end
  end
`else
  assign entry = mul_res;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        res_mem[i] <= '0;
        tag_mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        res_mem[wr_ptr[PW-1:0]] <= entry;
        tag_mem[wr_ptr[PW-1:0]] <= tpipe[LAT];
        wr_ptr                  <= wr_ptr + ONE;
      end
      if (pop) rd_ptr <= rd_ptr + ONE;
    end
  end

  // Credits count in-flight products too, so a FIFO slot always exists when a product lands.
  always_comb begin
    out_next = outstanding;
    if (issue && !pop)      out_next = outstanding + ONE;
    else if (!issue && pop) out_next = outstanding - ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding <= '0;
      s_ready     <= 1'b0;
    end else begin
      outstanding <= out_next;
      s_ready     <= (out_next < DEPTH_C);
    end
  end

  assert property (@(posedge clk) disable iff (!rstn) !(wr_en && full));
  assert property (@(posedge clk) disable iff (!rstn) !(pop && !m_valid));

endmodule
